// File: rtl/ahfp_fixed_2_float_pipe.sv
// Purpose : signed fixed-point to {sign, exp, man} float converter, three pipeline stages.
// Latency : 3 enabled cycles from input transfer to out_valid; 1 result/cycle sustained.
// Backpr. : all stages advance together on en = !out_valid | out_ready; in_ready = en.
//
// Ports   : clk, rst (sync, active-high), in_valid/in_ready/in (IN_WIDTH two's complement),
//           out_valid/out_ready/out ({sign, exp[EXP_WIDTH], man[MAN_WIDTH]}).
// Option  : define AHFP_F2F_ROUND_EN for round-to-nearest-even; otherwise magnitude truncation.
module ahfp_fixed_2_float_pipe #(
    parameter int IN_WIDTH  = 32,
    parameter int FRAC_BITS = 16,
    parameter int EXP_WIDTH = 8,
    parameter int MAN_WIDTH = 23
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [IN_WIDTH-1:0]            in,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [EXP_WIDTH+MAN_WIDTH:0]   out
);

    localparam int BIAS  = 2 ** (EXP_WIDTH - 1) - 1;
    localparam int PW    = $clog2(IN_WIDTH);
    localparam int EMW   = EXP_WIDTH + MAN_WIDTH;
    localparam int OUT_W = EMW + 1;

    // The exponent range must cover every possible leading-one position so that
    // no denormal, infinity or overflow encoding is ever needed.
    generate
        if ((BIAS - FRAC_BITS < 1) || (BIAS + IN_WIDTH - FRAC_BITS > 2 ** EXP_WIDTH - 2)
            || (IN_WIDTH < 2)) begin : g_bad_params
            $error("ahfp_fixed_2_float_pipe: exponent range cannot represent the input range");
        end
    endgenerate

    logic en;

    // stage 1: sign / magnitude / zero
    logic                s1_vld_q,  s1_vld_d;
    logic                s1_sign_q, s1_sign_d;
    logic                s1_zero_q, s1_zero_d;
    logic [IN_WIDTH-1:0] s1_mag_q,  s1_mag_d;

    // stage 2: leading-one position
    logic                s2_vld_q,  s2_vld_d;
    logic                s2_sign_q, s2_sign_d;
    logic                s2_zero_q, s2_zero_d;
    logic [IN_WIDTH-1:0] s2_mag_q,  s2_mag_d;
    logic [PW-1:0]       s2_p_q,    s2_p_d;
    logic [PW-1:0]       lod_p;

    // stage 3: packed result
    logic                out_vld_q, out_vld_d;
    logic [OUT_W-1:0]    out_dat_q, out_dat_d;
    logic [EXP_WIDTH-1:0] exp_t;
    logic [MAN_WIDTH-1:0] man_t;
    logic [EMW-1:0]       em_t;

`ifdef AHFP_F2F_ROUND_EN
    localparam int WW = IN_WIDTH + MAN_WIDTH;
    logic [WW-1:0] lost_sh;
    logic          guard, sticky, rnd_inc;
`endif

    assign en        = !out_vld_q || out_ready;
    assign in_ready  = en;
    assign out_valid = out_vld_q;
    assign out       = out_dat_q;

    always_comb begin
        s1_vld_d  = s1_vld_q;
        s1_sign_d = s1_sign_q;
        s1_zero_d = s1_zero_q;
        s1_mag_d  = s1_mag_q;
        if (en) begin
            s1_vld_d  = in_valid;
            s1_sign_d = in[IN_WIDTH-1];
            s1_zero_d = (in == '0);
            // Two's-complement negate; the most-negative input maps onto 2^(IN_WIDTH-1)
            // which is still representable as an unsigned IN_WIDTH-bit magnitude.
            s1_mag_d  = in[IN_WIDTH-1] ? ((~in) + IN_WIDTH'(1)) : in;
        end
    end

    always_comb begin
        lod_p = '0;
        for (int i = 0; i < IN_WIDTH; i++) begin
            if (s1_mag_q[i]) lod_p = PW'(i);
        end
    end

    always_comb begin
        s2_vld_d  = s2_vld_q;
        s2_sign_d = s2_sign_q;
        s2_zero_d = s2_zero_q;
        s2_mag_d  = s2_mag_q;
        s2_p_d    = s2_p_q;
        if (en) begin
            s2_vld_d  = s1_vld_q;
            s2_sign_d = s1_sign_q;
            s2_zero_d = s1_zero_q;
            s2_mag_d  = s1_mag_q;
            s2_p_d    = lod_p;
        end
    end

    always_comb begin
        exp_t = EXP_WIDTH'(BIAS - FRAC_BITS) + EXP_WIDTH'(s2_p_q);
        // Append MAN_WIDTH zeros then shift right by p: the MAN_WIDTH bits below the
        // leading one land left-aligned in the low field, zero-filled when p <= MAN_WIDTH.
        man_t = MAN_WIDTH'({s2_mag_q, {MAN_WIDTH{1'b0}}} >> s2_p_q);
        em_t  = {exp_t, man_t};
`ifdef AHFP_F2F_ROUND_EN
        // Move the bits that fell off the bottom up to the top: the first dropped bit
        // becomes the MSB (guard), the rest form sticky.
        lost_sh = {s2_mag_q, {MAN_WIDTH{1'b0}}} << (WW - int'(s2_p_q));
        guard   = lost_sh[WW-1];
        sticky  = |lost_sh[WW-2:0];
        rnd_inc = guard && (sticky || man_t[0]);
        // A carry out of the mantissa ripples into the exponent field directly.
        em_t    = em_t + {{(EMW-1){1'b0}}, rnd_inc};
`endif
    end

    always_comb begin
        out_vld_d = out_vld_q;
        out_dat_d = out_dat_q;
        if (en) begin
            out_vld_d = s2_vld_q;
            out_dat_d = s2_zero_q ? '0 : {s2_sign_q, em_t};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_q  <= 1'b0;
            s1_sign_q <= 1'b0;
            s1_zero_q <= 1'b0;
            s1_mag_q  <= '0;
            s2_vld_q  <= 1'b0;
            s2_sign_q <= 1'b0;
            s2_zero_q <= 1'b0;
            s2_mag_q  <= '0;
            s2_p_q    <= '0;
            out_vld_q <= 1'b0;
            out_dat_q <= '0;
        end else begin
            s1_vld_q  <= s1_vld_d;
            s1_sign_q <= s1_sign_d;
            s1_zero_q <= s1_zero_d;
            s1_mag_q  <= s1_mag_d;
            s2_vld_q  <= s2_vld_d;
            s2_sign_q <= s2_sign_d;
            s2_zero_q <= s2_zero_d;
            s2_mag_q  <= s2_mag_d;
            s2_p_q    <= s2_p_d;
            out_vld_q <= out_vld_d;
            out_dat_q <= out_dat_d;
        end
    end

endmodule

// File: tb/tb_ahfp_fixed_2_float_pipe.sv
// Scoreboard bench for ahfp_fixed_2_float_pipe at default parameters.
// Stimulus pushes hand-computed expected words; a negedge monitor pops on each output handshake.
module tb_ahfp_fixed_2_float_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_dat = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_dat;

    always #5 clk = ~clk;

    ahfp_fixed_2_float_pipe #(
        .IN_WIDTH (32),
        .FRAC_BITS(16),
        .EXP_WIDTH(8),
        .MAN_WIDTH(23)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in       (in_dat),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out      (out_dat)
    );

`ifdef AHFP_F2F_ROUND_EN
    localparam logic [31:0] EXP_MAXPOS = 32'h47000000;
    localparam logic [31:0] EXP_R3     = 32'h43800002;
`else
    localparam logic [31:0] EXP_MAXPOS = 32'h46FFFFFF;
    localparam logic [31:0] EXP_R3     = 32'h43800001;
`endif

    typedef struct {
        logic [31:0] exp;
        int          cyc;
        bit          lat;
    } sb_t;

    sb_t         q[$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] cur_exp = '0;
    bit          lat_mode = 1'b1;

    logic [31:0] vin [10] = '{32'h00010000, 32'hFFFF0000, 32'h00000000, 32'h80000000,
                              32'h7FFFFFFF, 32'h01000001, 32'h01000003, 32'h00008000,
                              32'h00000001, 32'hFFFFFFFF};
    logic [31:0] vexp[10] = '{32'h3F800000, 32'hBF800000, 32'h00000000, 32'hC7000000,
                              EXP_MAXPOS,   32'h43800000, EXP_R3,       32'h3F000000,
                              32'h37800000, 32'hB7800000};
    logic [31:0] bin [6]  = '{32'h00010000, 32'h00020000, 32'h00030000,
                              32'h00040000, 32'h00050000, 32'h00060000};
    logic [31:0] bexp[6]  = '{32'h3F800000, 32'h40000000, 32'h40400000,
                              32'h40800000, 32'h40A00000, 32'h40C00000};

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor / scoreboard
    always @(negedge clk) begin
        sb_t e;
        if (rst) begin
            q.delete();
        end else begin
            if (out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL stale_out: got out=%h with no pending input", out_dat);
                end else begin
                    e = q.pop_front();
                    if (out_dat !== e.exp) begin
                        errors++;
                        $display("FAIL out_value: got %h, expected %h", out_dat, e.exp);
                    end
                    if (e.lat) begin
                        checks++;
                        if (cyc - e.cyc != 3) begin
                            errors++;
                            $display("FAIL latency: got %0d cycles, expected 3", cyc - e.cyc);
                        end
                    end
                end
            end
            if (in_valid && in_ready) q.push_back('{cur_exp, cyc, lat_mode});
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Present one word and hold it until the edge that accepts it.
    task automatic send(input logic [31:0] v, input logic [31:0] e);
        int n;
        bit ok;
        n        = 0;
        in_valid = 1'b1;
        in_dat   = v;
        cur_exp  = e;
        forever begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            n++;
            if (ok) break;
            if (n > 50) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: in_ready got 0 for %0d cycles, expected 1", n);
                break;
            end
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation got no end, expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        // Reset
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out",       out_dat,            32'd0);
        chk("rst_in_ready",  {31'b0, in_ready},  32'd1);
        @(posedge clk);
        #1;

        // Directed value table, back to back
        lat_mode = 1'b1;
        for (int i = 0; i < 10; i++) send(vin[i], vexp[i]);
        idle(6);

        // Backpressure: stall 4 cycles once the first result is presented
        lat_mode = 1'b0;
        for (int i = 0; i < 3; i++) send(bin[i], bexp[i]);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("stall_out_valid", {31'b0, out_valid}, 32'd1);
            chk("stall_out_hold",  out_dat,            32'h3F800000);
            chk("stall_in_ready",  {31'b0, in_ready},  32'd0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("drain_consec_valid", {31'b0, out_valid}, 32'd1);
            chk("drain_consec_value", out_dat,            bexp[i]);
        end
        @(negedge clk);
        chk("drain_no_dup", {31'b0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        lat_mode = 1'b1;

        // Reset with two words in flight
        send(32'h00050000, 32'h40A00000);
        send(32'h00060000, 32'h40C00000);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_no_valid", {31'b0, out_valid}, 32'd0);
        end
        @(posedge clk);
        #1;
        send(32'h00020000, 32'h40000000);
        idle(5);

        // Bubbles: alternate valid / idle
        for (int i = 0; i < 6; i++) begin
            send(bin[i], bexp[i]);
            idle(1);
        end
        idle(5);

        // Everything issued must have come out
        n = 0;
        while (q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain_empty: got %0d outstanding results, expected 0", q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ahfp_fixed_2_float_pipe.md
Name: ahfp_fixed_2_float_pipe

Overview:
- Parametrised, fully pipelined signed fixed-point to IEEE-754-style float converter for the AHFP datapath.
- Generalises the single-width converter: configurable input width, fraction position, exponent and mantissa widths.
- Adds valid/ready handshake with backpressure, exact zero encoding, and correct most-negative-input handling; optional round-to-nearest-even.
- Sits between fixed-point accumulators and float consumers.

Parameters:
- IN_WIDTH, 32, two's-complement input width.
- FRAC_BITS, 16, fractional bits of the input; value = in / 2^FRAC_BITS.
- EXP_WIDTH, 8, float exponent field width; bias = 2^(EXP_WIDTH-1)-1.
- MAN_WIDTH, 23, stored mantissa field width (hidden bit implicit).

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  input word valid.
- in_ready  output  1  block accepts input this cycle.
- in  input  IN_WIDTH  signed fixed-point operand.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out  output  1+EXP_WIDTH+MAN_WIDTH  {sign, exp, man}.

Behaviour:
- Reset: one clock; the polarity and synchronicity are fixed (synchronous, active-high). rst high at a clk edge clears all stage valid bits. out_valid=0, out=0. in_ready=1 from the first cycle after reset. In-flight data is discarded.
- Pipeline enable: en = !out_valid | out_ready. All three stages advance together only when en=1. in_ready = en (combinational). A transfer occurs on a clk edge with in_valid & in_ready. Output handshake is out_valid & out_ready.
- Stage 1: register sign = in[IN_WIDTH-1] and mag = |in| as an IN_WIDTH-bit unsigned value. The most-negative input gives mag = 2^(IN_WIDTH-1) with no overflow. Also register zero = (in==0).
- Stage 2: leading-one detect on mag. Register p = index of the MSB set, plus mag, sign and zero.
- Stage 3: normalise and pack.
  - exp = bias + p - FRAC_BITS.
  - Mantissa = the MAN_WIDTH bits below bit p, left-aligned.
  - If p <= MAN_WIDTH, zero-fill on the right; the result is exact.
  - If p > MAN_WIDTH, discard the low bits, or round them (see Optional Feature).
- Latency: exactly 3 accepted-enable cycles from input transfer to out_valid. Throughput: 1 result/cycle with out_ready held high.
- Zero: out = all zeros (sign 0) and out_valid asserted normally.
- Rounding carry: a mantissa overflow to 2^(MAN_WIDTH+1) sets man=0 and exp+1.
- Parameter constraints: bias-FRAC_BITS >= 1 and bias+IN_WIDTH-FRAC_BITS <= 2^EXP_WIDTH-2. Under these constraints no denormal, infinity or overflow output is possible. Elaboration fails via a generate-time error if the constraints are violated.
- Stall: while out_valid=1 and out_ready=0, out and every stage register hold their values, and in_ready=0.
- in_valid=0 while en=1: a bubble (valid=0) propagates through the stages.

Optional Feature:
- Macro AHFP_F2F_ROUND_EN.
- Defined: round-to-nearest-even on discarded bits, using guard = first dropped bit and sticky = OR of the remaining dropped bits. Increment when guard & (sticky | man_lsb). Latency is unchanged (rounding sits in stage 3).
- Undefined: truncation toward zero of magnitude. No round logic is synthesised.

Test Plan (default parameters):
- Basic values: in=0x00010000 -> 0x3F800000; 0xFFFF0000 -> 0xBF800000; 0x00000000 -> 0x00000000. Each out_valid exactly 3 cycles after the transfer.
- Most negative: in=0x80000000 -> 0xC7000000.
- Rounding:
  - in=0x7FFFFFFF -> 0x47000000 with AHFP_F2F_ROUND_EN (carry into exp); 0x46FFFFFF without.
  - in=0x01000001 -> 0x43800000 in both builds (tie to even).
  - in=0x01000003 -> 0x43800002 with the macro; 0x43800001 without.
- Backpressure:
  - Stream 1.0, 2.0 and 3.0 (0x00010000, 0x00020000, 0x00030000) back to back.
  - Drop out_ready for 4 cycles once out_valid rises.
  - Required: out holds 0x3F800000 and in_ready=0 during the stall.
  - Then 0x40000000 and 0x40400000 follow on consecutive cycles. No loss or duplication.
- Reset mid-operation: accept two inputs, assert rst for 1 cycle -> out_valid=0 next cycle. No stale result ever appears. A new input afterwards yields its result 3 cycles later.
- Bubbles: alternate in_valid 1/0 with out_ready=1 -> out_valid alternates with the same 3-cycle offset.
